// File: rtl/rps_pkg.sv
// Shared types for the rock/scissor/paper panel drawer: choice codes,
// screen geometry, blitter state encoding and a counter-width helper.
package rps_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        ROCK    = 2'd0,
        SCISSOR = 2'd1,
        PAPER   = 2'd2,
        BLANK   = 2'd3
    } choice_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/panel_blitter_if.sv
// Bundle between the game top, the sprite ROMs, vga_adapter and panel_blitter.
// state is a read-only debug view of the blitter FSM.
interface panel_blitter_if #(
    parameter int NUM_PANELS = 2,
    parameter int CHOICE_W   = 2,
    parameter int COLOUR_W   = 3,
    parameter int ADDR_W     = 15
);
    import rps_pkg::*;

    // start is sampled only while idle; busy is high from the cycle after
    // acceptance through the drain; done then pulses for one cycle with busy low.
    logic                           start;
    logic [NUM_PANELS*CHOICE_W-1:0] choice;
    logic [NUM_PANELS*COLOUR_W-1:0] fg_colour;
    logic [NUM_PANELS*COLOUR_W-1:0] bg_colour;
    logic [ADDR_W-1:0]              rom_addr;
    logic [CHOICE_W-1:0]            rom_sel;
    logic                           rom_q;
    logic [7:0]                     x;
    logic [6:0]                     y;
    logic [COLOUR_W-1:0]            colour;
    logic                           plot;
    logic                           busy;
    logic                           done;
    blit_state_t                    state;

    modport master (
        output start, choice, fg_colour, bg_colour, rom_q,
        input  rom_addr, rom_sel, x, y, colour, plot, busy, done, state
    );

    modport slave (
        input  start, choice, fg_colour, bg_colour, rom_q,
        output rom_addr, rom_sel, x, y, colour, plot, busy, done, state
    );

endinterface

// File: rtl/delay_line.sv
// Fixed-depth shift register with synchronous clear; aligns pixel
// bookkeeping with the sprite ROM read latency.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/panel_blitter.sv
// Sweeps NUM_PANELS sprite panels into the 160x120 framebuffer with a
// start/busy/done handshake. Optional white panel border: PANEL_BORDER_EN.
module panel_blitter
    import rps_pkg::*;
#(
    parameter int NUM_PANELS  = 2,
    parameter int PANEL_W     = 80,
    parameter int PANEL_H     = 120,
    parameter int CHOICE_W    = 2,
    parameter int COLOUR_W    = 3,
    parameter int ROM_LATENCY = 1,
    parameter int ADDR_W      = 15
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    panel_blitter_if.slave  bus
);

    localparam int PX_W = cnt_w(PANEL_W);
    localparam int PY_W = cnt_w(PANEL_H);
    localparam int PN_W = cnt_w(NUM_PANELS);
    localparam int DR_W = cnt_w(ROM_LATENCY);
    localparam int AW1  = ADDR_W + 1;

    if (NUM_PANELS * PANEL_W > SCREEN_W) begin : g_bad_width
        $error("panel_blitter: NUM_PANELS*PANEL_W exceeds the screen width");
    end
    if (PANEL_H > SCREEN_H) begin : g_bad_height
        $error("panel_blitter: PANEL_H exceeds the screen height");
    end
    if (longint'(PANEL_W) * longint'(PANEL_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("panel_blitter: sprite does not fit the ROM address space");
    end
    if (ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_latency
        $error("panel_blitter: ROM_LATENCY must be 1..3");
    end

    blit_state_t         state, state_nxt;
    logic [PX_W-1:0]     px;
    logic [PY_W-1:0]     py;
    logic [PN_W-1:0]     panel;
    logic [DR_W-1:0]     drain_cnt;
    logic [CHOICE_W-1:0] choice_lat [NUM_PANELS];
    logic [COLOUR_W-1:0] fg_lat     [NUM_PANELS];
    logic [COLOUR_W-1:0] bg_lat     [NUM_PANELS];

    logic load, step, sweeping;
    logic last_px, last_py, last_panel, last_addr, drain_end;

    assign sweeping   = (state == ST_SWEEP);
    assign last_px    = (px == PX_W'(PANEL_W - 1));
    assign last_py    = (py == PY_W'(PANEL_H - 1));
    assign last_panel = (panel == PN_W'(NUM_PANELS - 1));
    assign last_addr  = last_px && last_py && last_panel;
    assign drain_end  = (drain_cnt == DR_W'(ROM_LATENCY - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                step = 1'b1;
                if (last_addr) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_end) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sweep counters and the per-redraw snapshot of the game inputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            px        <= '0;
            py        <= '0;
            panel     <= '0;
            drain_cnt <= '0;
            for (int i = 0; i < NUM_PANELS; i++) begin
                choice_lat[i] <= '0;
                fg_lat[i]     <= '0;
                bg_lat[i]     <= '0;
            end
        end else begin
            if (load) begin
                px        <= '0;
                py        <= '0;
                panel     <= '0;
                drain_cnt <= '0;
                for (int i = 0; i < NUM_PANELS; i++) begin
                    choice_lat[i] <= bus.choice[i*CHOICE_W +: CHOICE_W];
                    fg_lat[i]     <= bus.fg_colour[i*COLOUR_W +: COLOUR_W];
                    bg_lat[i]     <= bus.bg_colour[i*COLOUR_W +: COLOUR_W];
                end
            end else if (step && !last_addr) begin
                if (!last_px) begin
                    px <= px + 1'b1;
                end else begin
                    px <= '0;
                    if (!last_py) begin
                        py <= py + 1'b1;
                    end else begin
                        py    <= '0;
                        panel <= panel + 1'b1;
                    end
                end
            end
            if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        end
    end

    logic [AW1-1:0] addr_full;
    logic [7:0]     x_full;
    logic [6:0]     y_full;

    assign addr_full = AW1'(py) * AW1'(PANEL_W) + AW1'(px);
    assign x_full    = 8'(panel) * 8'(PANEL_W) + 8'(px);
    assign y_full    = 7'(py);

    assign bus.rom_addr = sweeping ? addr_full[ADDR_W-1:0] : '0;
    assign bus.rom_sel  = sweeping ? choice_lat[panel] : '0;

    logic            valid_d;
    logic [7:0]      x_d;
    logic [6:0]      y_d;
    logic [PN_W-1:0] panel_d;

`ifdef PANEL_BORDER_EN
    localparam int PAY_W = 17 + PN_W;
    logic on_border, border_d;
    assign on_border = (px == '0) || last_px || (py == '0) || last_py;
`else
    localparam int PAY_W = 16 + PN_W;
`endif

    logic [PAY_W-1:0] pay_in, pay_out;

`ifdef PANEL_BORDER_EN
    assign pay_in = {sweeping, x_full, y_full, panel, on_border};
    assign {valid_d, x_d, y_d, panel_d, border_d} = pay_out;
`else
    assign pay_in = {sweeping, x_full, y_full, panel};
    assign {valid_d, x_d, y_d, panel_d} = pay_out;
`endif

    delay_line #(
        .WIDTH (PAY_W),
        .DEPTH (ROM_LATENCY)
    ) u_align (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     (pay_in),
        .q     (pay_out)
    );

    // rom_q=1 is background; a blank panel never shows its sprite.
    logic [COLOUR_W-1:0] pix_colour;
    always_comb begin
        pix_colour = fg_lat[panel_d];
        if (bus.rom_q || (choice_lat[panel_d] == CHOICE_W'(BLANK)))
            pix_colour = bg_lat[panel_d];
`ifdef PANEL_BORDER_EN
        if (border_d) pix_colour = '1;
`endif
    end

    assign bus.plot   = valid_d;
    assign bus.x      = valid_d ? x_d : '0;
    assign bus.y      = valid_d ? y_d : '0;
    assign bus.colour = valid_d ? pix_colour : '0;
    assign bus.busy   = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign bus.done   = (state == ST_DONE);
    assign bus.state  = state;

endmodule

// File: tb/tb_panel_blitter.sv
// Bench for panel_blitter: ROM model with selectable content, a pixel-level
// reference built from the drawing rules, and per-scenario checks.
module tb_panel_blitter;
    import rps_pkg::*;

`ifdef PANEL_BORDER_EN
    localparam int NP  = 3;
    localparam int PW  = 50;
    localparam int LAT = 2;
`else
    localparam int NP  = 2;
    localparam int PW  = 80;
    localparam int LAT = 1;
`endif
    localparam int PH    = 120;
    localparam int CHW   = 2;
    localparam int CW    = 3;
    localparam int AW    = 15;
    localparam int SPR   = PW * PH;
    localparam int TOTAL = NP * SPR;
    localparam int EW    = 8 + 7 + CW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    panel_blitter_if #(.NUM_PANELS(NP), .CHOICE_W(CHW), .COLOUR_W(CW), .ADDR_W(AW)) bif ();

    panel_blitter #(
        .NUM_PANELS(NP), .PANEL_W(PW), .PANEL_H(PH), .CHOICE_W(CHW),
        .COLOUR_W(CW), .ROM_LATENCY(LAT), .ADDR_W(AW)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bif)
    );

    int errors = 0;
    int checks = 0;

    // ROM content: 0 diagonal (px==py), 1 all ones, 2 all zeros, 3 hashed by address and sprite.
    int qmode = 0;
    function automatic logic rom_fn(int mode, int addr, int sel);
        logic [31:0] h;
        case (mode)
            0: return (addr % PW) == (addr / PW);
            1: return 1'b1;
            2: return 1'b0;
            default: begin
                h = 32'(addr) * 32'd2654435761 ^ (32'(sel) * 32'd40503);
                return h[13] ^ h[7];
            end
        endcase
    endfunction

    logic rom_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) rom_pipe[i] = 1'b0;
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(qmode, int'(bif.rom_addr), int'(bif.rom_sel));
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bif.rom_q = rom_pipe[LAT-1];

    logic [CHW-1:0] cur_choice [NP];
    logic [CW-1:0]  cur_fg     [NP];
    logic [CW-1:0]  cur_bg     [NP];
    logic [EW-1:0]  exp_q [$];

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            bif.choice[i*CHW +: CHW]   = cur_choice[i];
            bif.fg_colour[i*CW +: CW]  = cur_fg[i];
            bif.bg_colour[i*CW +: CW]  = cur_bg[i];
        end
    endtask

    function automatic logic [CW-1:0] ref_colour(int p, int px, int py);
`ifdef PANEL_BORDER_EN
        if (px == 0 || px == PW - 1 || py == 0 || py == PH - 1) return '1;
`endif
        if (cur_choice[p] == 2'd3) return cur_bg[p];
        return rom_fn(qmode, py * PW + px, int'(cur_choice[p])) ? cur_bg[p] : cur_fg[p];
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int p = 0; p < NP; p++)
            for (int py = 0; py < PH; py++)
                for (int px = 0; px < PW; px++)
                    exp_q.push_back({8'(p * PW + px), 7'(py), ref_colour(p, px, py)});
    endtask

    // Observations from one redraw; the test tasks judge them.
    int first_busy, first_plot, last_plot, plots, done_cnt, done_cyc;
    int pix_bad, addr_bad, sel_bad, max_x, extra, first_bad_idx;
    logic busy_at_done, plot_after, busy_after, timed_out;
    logic [EW-1:0] first_got, first_want;

    task automatic run_sweep(input int abort_at, input bit disturb);
        int cyc;
        bit finished;
        logic [EW-1:0] got, want;
        first_busy = -1; first_plot = -1; last_plot = -1; plots = 0;
        done_cnt = 0; done_cyc = -1; pix_bad = 0; addr_bad = 0; sel_bad = 0;
        max_x = -1; extra = 0; first_bad_idx = -1; busy_at_done = 1'bx;
        plot_after = 1'bx; busy_after = 1'bx; timed_out = 1'b0;
        first_got = '0; first_want = '0;
        @(negedge clk); bif.start = 1'b1;
        @(negedge clk); bif.start = 1'b0;
        cyc = 0; finished = 0;
        while (!finished && cyc < TOTAL + 100) begin
            if (bif.busy === 1'b1 && first_busy < 0) first_busy = cyc;
            if (first_busy >= 0 && cyc - first_busy < TOTAL) begin
                if (bif.rom_addr !== AW'((cyc - first_busy) % SPR)) addr_bad++;
                if (bif.rom_sel !== cur_choice[(cyc - first_busy) / SPR]) sel_bad++;
            end
            if (bif.plot === 1'b1) begin
                got = {bif.x, bif.y, bif.colour};
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (got !== want) begin
                    if (pix_bad == 0) begin
                        first_bad_idx = plots; first_got = got; first_want = want;
                    end
                    pix_bad++;
                end
                if (first_plot < 0) first_plot = cyc;
                if (int'(bif.x) > max_x) max_x = int'(bif.x);
                last_plot = cyc;
                plots++;
            end
            if (bif.done === 1'b1) begin
                done_cnt++; done_cyc = cyc; busy_at_done = bif.busy; finished = 1;
            end
            if (disturb && first_busy >= 0 && cyc == first_busy + 1000) begin
                bif.start     = 1'b1;
                bif.choice    = (NP*CHW)'($urandom);
                bif.fg_colour = (NP*CW)'($urandom);
                bif.bg_colour = (NP*CW)'($urandom);
            end
            if (disturb && first_busy >= 0 && cyc == first_busy + 1001) bif.start = 1'b0;
            if (abort_at > 0 && plots == abort_at && !finished) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                plot_after = bif.plot;
                busy_after = bif.busy;
                repeat (30) begin
                    @(negedge clk);
                    if (bif.done !== 1'b0) done_cnt++;
                    if (bif.plot !== 1'b0) extra++;
                end
                finished = 1;
            end else if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) timed_out = 1'b1;
        if (abort_at == 0) begin
            repeat (5) begin
                @(negedge clk);
                if (bif.plot !== 1'b0) extra++;
                if (bif.done !== 1'b0) done_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NP; i++) begin
            cur_choice[i] = '0; cur_fg[i] = '0; cur_bg[i] = '0;
        end
        drive_inputs();
        bif.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bif.plot, bif.busy, bif.done} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {bif.plot, bif.busy, bif.done});
        end
        checks++;
        if ({bif.x, bif.y, bif.colour, bif.rom_addr, bif.rom_sel} !== '0) begin
            errors++; $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d addr=%0d sel=%0d want all 0",
                                bif.x, bif.y, bif.colour, bif.rom_addr, bif.rom_sel);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b0 || bif.plot !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b plot=%b want 0 0", bif.busy, bif.plot);
        end
    endtask

    task automatic test_sweep_basic();
        qmode = 0;
        for (int i = 0; i < NP; i++) begin
            cur_choice[i] = CHW'(i % 3);
            cur_fg[i] = CW'($urandom_range(0, 7));
            cur_bg[i] = CW'($urandom_range(0, 7));
        end
        drive_inputs();
        build_expected();
        run_sweep(0, 0);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
        checks++;
        if (first_busy !== 0) begin errors++; $display("FAIL basic_busy_start: got %0d want 0", first_busy); end
        checks++;
        if (first_plot - first_busy !== LAT) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", first_plot - first_busy, LAT);
        end
        checks++;
        if (plots !== TOTAL) begin errors++; $display("FAIL basic_plot_count: got %0d want %0d", plots, TOTAL); end
        checks++;
        if (pix_bad !== 0) begin
            errors++; $display("FAIL basic_pixels: got %0d bad (first #%0d got %h want %h) want 0",
                                pix_bad, first_bad_idx, first_got, first_want);
        end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("FAIL basic_rom_addr: got %0d bad want 0", addr_bad); end
        checks++;
        if (sel_bad !== 0) begin errors++; $display("FAIL basic_rom_sel: got %0d bad want 0", sel_bad); end
        checks++;
        if (max_x !== NP * PW - 1) begin errors++; $display("FAIL basic_max_x: got %0d want %0d", max_x, NP * PW - 1); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (done_cyc !== last_plot + 1) begin
            errors++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_plot + 1);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL basic_tail_activity: got %0d want 0", extra); end
    endtask

    task automatic test_colour_q1();
        qmode = 1;
        for (int i = 0; i < NP; i++) begin
            cur_choice[i] = CHW'($urandom_range(0, 2));
            cur_fg[i] = 3'b010;
            cur_bg[i] = (i == 0) ? 3'b111 : 3'b000;
        end
        drive_inputs();
        build_expected();
        run_sweep(0, 0);
        checks++;
        if (plots !== TOTAL) begin errors++; $display("FAIL q1_plot_count: got %0d want %0d", plots, TOTAL); end
        checks++;
        if (pix_bad !== 0) begin
            errors++; $display("FAIL q1_pixels: got %0d bad (first #%0d got %h want %h) want 0",
                                pix_bad, first_bad_idx, first_got, first_want);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL q1_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        qmode = 2;
        for (int i = 0; i < NP; i++) begin
            cur_choice[i] = CHW'($urandom_range(0, 2));
            cur_fg[i] = 3'b010;
            cur_bg[i] = (i == 0) ? 3'b111 : 3'b000;
        end
        drive_inputs();
        build_expected();
        run_sweep(5000, 0);
        checks++;
        if (plots !== 5000) begin errors++; $display("FAIL abort_plot_count: got %0d want 5000", plots); end
        checks++;
        if (pix_bad !== 0) begin
            errors++; $display("FAIL abort_q0_pixels: got %0d bad (first #%0d got %h want %h) want 0",
                                pix_bad, first_bad_idx, first_got, first_want);
        end
        checks++;
        if ({plot_after, busy_after} !== 2'b00) begin
            errors++; $display("FAIL abort_next_cycle: got plot=%b busy=%b want 0 0", plot_after, busy_after);
        end
        checks++;
        if (done_cnt !== 0 || extra !== 0) begin
            errors++; $display("FAIL abort_quiet: got done=%0d plots=%0d want 0 0", done_cnt, extra);
        end
    endtask

    task automatic test_blank_mid_sweep();
        qmode = 3;
        for (int i = 0; i < NP; i++) begin
            cur_choice[i] = (i == 1) ? 2'd3 : CHW'($urandom_range(0, 2));
            cur_fg[i] = CW'($urandom_range(0, 7));
            cur_bg[i] = CW'($urandom_range(0, 7));
            if (cur_fg[i] == cur_bg[i]) cur_fg[i] = ~cur_bg[i];
        end
        drive_inputs();
        build_expected();
        run_sweep(0, 1);
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL blank_timeout: got %b want 0", timed_out); end
        checks++;
        if (plots !== TOTAL) begin errors++; $display("FAIL blank_plot_count: got %0d want %0d", plots, TOTAL); end
        checks++;
        if (pix_bad !== 0) begin
            errors++; $display("FAIL blank_pixels: got %0d bad (first #%0d got %h want %h) want 0",
                                pix_bad, first_bad_idx, first_got, first_want);
        end
        checks++;
        if (sel_bad !== 0) begin errors++; $display("FAIL blank_rom_sel: got %0d bad want 0", sel_bad); end
        checks++;
        if (addr_bad !== 0) begin errors++; $display("FAIL blank_rom_addr: got %0d bad want 0", addr_bad); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL blank_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        bif.start = 1'b0;
        test_reset();
        test_sweep_basic();
        test_colour_q1();
        test_reset_abort();
        test_blank_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
